// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//
// Bundles the front-panel control pulses, the instruction-memory write/read
// port and the loader status outputs into one interface.
//
// Control pulses (Start, Strobe, Finish) are single-cycle, single-shot
// requests. There is no ready or back-pressure path. The loader samples a
// pulse on the clock edge and acts on it only if its current state accepts
// it. A pulse that arrives in a state that does not accept it is discarded,
// not queued. Busy=1 marks the cycles in which Strobe and Finish are
// discarded.
//
// Modports
//   master : front panel / memory side (drives the pulses, DataIn and
//            Mem_RdData; observes everything else)
//   slave  : the loader itself
//
// Signals
//   Start, Strobe, Finish : one-cycle control pulses
//   DataIn                : word keyed in on the switches
//   Mem_RdData            : memory read data, one cycle after Mem_Addr
//   Mem_Addr              : memory address
//   Mem_WrData            : memory write data
//   Mem_WrEn              : write enable, one cycle per word
//   ProcHold              : hold the processor in reset
//   Count                 : words written this session
//   Busy, Done, Error     : loader status
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              Start;
    logic              Strobe;
    logic              Finish;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] Mem_RdData;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WrData;
    logic              Mem_WrEn;
    logic              ProcHold;
    logic [ADDR_W:0]   Count;
    logic              Busy;
    logic              Done;
    logic              Error;

    modport master (
        output Start, Strobe, Finish, DataIn, Mem_RdData,
        input  Mem_Addr, Mem_WrData, Mem_WrEn, ProcHold, Count, Busy, Done, Error
    );

    modport slave (
        input  Start, Strobe, Finish, DataIn, Mem_RdData,
        output Mem_Addr, Mem_WrData, Mem_WrEn, ProcHold, Count, Busy, Done, Error
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Front-panel program loader. Each accepted Strobe writes the switch word
// DataIn into the next instruction-memory address, starting at 0. The
// processor is held in reset while a session is in progress.
//
// Optional feature macro: LOADER_VERIFY_EN
//   defined   : every write is read back and compared. A mismatch stops the
//               session in ERR with Error=1.
//   undefined : WRITE returns straight to WAIT, Error is tied low and
//               Mem_RdData is ignored.
//
// Ports
//   Clk       : system clock
//   Reset     : synchronous, active-high reset
//   bus       : prog_loader_if.slave (control pulses, memory port, status)
//   dbg_state : current FSM state, for observation only
//
// All outputs come straight from flops. The flags are loaded from the
// next-state value, so they change on the same edge as the state register.
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    prog_loader_if.slave bus,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        WRITE = 3'd2,
        VRD   = 3'd3,
        VCMP  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q, next_state;
    logic [ADDR_W:0]   count_q;         // doubles as the write pointer
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q, hold_q, busy_q, done_q;
    logic              start_session;   // clear pointer/count for a new session
    logic              accept_strobe;   // latch DataIn and the target address
    logic              advance;         // word committed: bump pointer/count

    always_comb begin
        next_state    = state_q;
        start_session = 1'b0;
        accept_strobe = 1'b0;
        advance       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    next_state    = WAIT;
                    start_session = 1'b1;
                end
            end
            WAIT: begin
                // A full memory ends the session by itself. Finish beats
                // a simultaneous Strobe.
                if (count_q == DEPTH_C || bus.Finish) begin
                    next_state = DONE;
                end else if (bus.Strobe) begin
                    next_state    = WRITE;
                    accept_strobe = 1'b1;
                end
            end
            WRITE: begin
`ifdef LOADER_VERIFY_EN
                next_state = VRD;
`else
                next_state = WAIT;
                advance    = 1'b1;
`endif
            end
            VRD: next_state = VCMP;
            VCMP: begin
`ifdef LOADER_VERIFY_EN
                if (bus.Mem_RdData == wr_data_q) begin
                    next_state = WAIT;
                    advance    = 1'b1;
                end else begin
                    next_state = ERR;
                end
`else
                next_state = WAIT;
`endif
            end
            DONE: begin
                if (bus.Start) begin
                    next_state    = WAIT;
                    start_session = 1'b1;
                end
            end
            ERR: begin
                if (bus.Start) begin
                    next_state    = WAIT;
                    start_session = 1'b1;
                end else if (bus.Finish) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= next_state;
            if (start_session) begin
                count_q <= '0;
                addr_q  <= '0;
            end else if (advance && count_q != DEPTH_C) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end
            // Mem_Addr is captured here and held through VRD/VCMP, so an
            // ERR leaves it on the failing address.
            if (accept_strobe) begin
                wr_data_q <= bus.DataIn;
                addr_q    <= count_q[ADDR_W-1:0];
            end
            wr_en_q <= (next_state == WRITE);
            busy_q  <= (next_state == WRITE) || (next_state == VRD) ||
                       (next_state == VCMP);
            hold_q  <= (next_state == WAIT) || (next_state == WRITE) ||
                       (next_state == VRD)  || (next_state == VCMP)  ||
                       (next_state == ERR);
            done_q  <= (next_state == DONE);
        end
    end

`ifdef LOADER_VERIFY_EN
    logic error_q;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= (next_state == ERR);
        end
    end
    assign bus.Error = error_q;
`else
    logic unused_rd;
    assign unused_rd = ^bus.Mem_RdData;
    assign bus.Error = 1'b0;
`endif

    assign bus.Mem_Addr   = addr_q;
    assign bus.Mem_WrData = wr_data_q;
    assign bus.Mem_WrEn   = wr_en_q;
    assign bus.ProcHold   = hold_q;
    assign bus.Count      = count_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
`ifdef LOADER_VERIFY_EN
  localparam int GAP = 3;  // cycles after the write pulse before the next strobe
  localparam bit VERIFY = 1'b1;
`else
  localparam int GAP = 1;
  localparam bit VERIFY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- synchronous RAM model ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q = '0;
  logic corrupt = 1'b0;
  always @(posedge clk) begin
    if (bus.Mem_WrEn === 1'b1) mem[bus.Mem_Addr] <= bus.Mem_WrData;
    if (corrupt && bus.Mem_Addr == 8'd2) rd_q <= ~mem[bus.Mem_Addr];
    else rd_q <= mem[bus.Mem_Addr];
  end
  assign bus.Mem_RdData = rd_q;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int m_ptr = 0;  // model: next address to be written this session
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write pulse must match the next expected (address, data) pair.
  always @(negedge clk) begin
    if (bus.Mem_WrEn === 1'b1) begin
      logic [ADDR_W+DATA_W-1:0] e;
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.Mem_Addr, bus.Mem_WrData);
      end else begin
        e = exp_q.pop_front();
        if ({bus.Mem_Addr, bus.Mem_WrData} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.Mem_Addr, bus.Mem_WrData, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    m_ptr = 0;
    chk("start_hold", 32'(bus.ProcHold), 32'd1);
    chk("start_count", 32'(bus.Count), 32'd0);
  endtask

  task automatic do_finish();
    bus.Finish = 1'b1;
    step();
    bus.Finish = 1'b0;
  endtask

  // One strobe from WAIT; verify_fail marks the word the RAM will corrupt.
  task automatic strobe_word(input logic [DATA_W-1:0] d, input bit verify_fail);
    bit accepted;
    accepted = (m_ptr < DEPTH);
    if (accepted) exp_q.push_back({m_ptr[ADDR_W-1:0], d});
    bus.DataIn = d;
    bus.Strobe = 1'b1;
    step();
    bus.Strobe = 1'b0;
    if (accepted) begin
      chk("strobe_wren", 32'(bus.Mem_WrEn), 32'd1);
      chk("strobe_busy", 32'(bus.Busy), 32'd1);
      if (!verify_fail) m_ptr++;
    end else begin
      chk("full_drop_wren", 32'(bus.Mem_WrEn), 32'd0);
    end
    repeat (GAP) step();
    chk("strobe_count", 32'(bus.Count), 32'(m_ptr));
  endtask

  task automatic check_reset_values();
    chk("rst_addr", 32'(bus.Mem_Addr), 32'd0);
    chk("rst_wrdata", 32'(bus.Mem_WrData), 32'd0);
    chk("rst_wren", 32'(bus.Mem_WrEn), 32'd0);
    chk("rst_hold", 32'(bus.ProcHold), 32'd0);
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_error", 32'(bus.Error), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    logic [DATA_W-1:0] words [3];
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    words[2] = 16'h0F0F;
    bus.Start = 1'b0;
    bus.Strobe = 1'b0;
    bus.Finish = 1'b0;
    bus.DataIn = '0;
    rst = 1'b1;
    repeat (3) step();
    check_reset_values();
    rst = 1'b0;
    step();

    // Three words, then Finish.
    base = wr_seen;
    do_start();
    for (int i = 0; i < 3; i++) strobe_word(words[i], 1'b0);
    chk("t1_hold_before_finish", 32'(bus.ProcHold), 32'd1);
    do_finish();
    chk("t1_done", 32'(bus.Done), 32'd1);
    chk("t1_hold_after_finish", 32'(bus.ProcHold), 32'd0);
    chk("t1_count", 32'(bus.Count), 32'd3);
    chk("t1_writes", 32'(wr_seen - base), 32'd3);

    // Strobe and Finish together: Finish wins, word dropped.
    do_start();
    strobe_word(16'h5555, 1'b0);
    base = wr_seen;
    bus.DataIn = 16'h7777;
    bus.Strobe = 1'b1;
    bus.Finish = 1'b1;
    step();
    bus.Strobe = 1'b0;
    bus.Finish = 1'b0;
    chk("t2_wren", 32'(bus.Mem_WrEn), 32'd0);
    step();
    chk("t2_done", 32'(bus.Done), 32'd1);
    chk("t2_count", 32'(bus.Count), 32'd1);
    chk("t2_writes", 32'(wr_seen - base), 32'd0);

    // Fill the memory: 257 strobes, only 256 writes, DONE without Finish.
    base = wr_seen;
    do_start();
    for (int i = 0; i < DEPTH + 1; i++) strobe_word(16'(i * 3 + 7), 1'b0);
    chk("t3_count", 32'(bus.Count), 32'd256);
    chk("t3_done", 32'(bus.Done), 32'd1);
    chk("t3_hold", 32'(bus.ProcHold), 32'd0);
    chk("t3_writes", 32'(wr_seen - base), 32'd256);

    // Strobe and Finish while Busy are dropped.
    base = wr_seen;
    do_start();
    exp_q.push_back({8'd0, 16'hBEEF});
    bus.DataIn = 16'hBEEF;
    bus.Strobe = 1'b1;
    step();
    chk("t4_busy", 32'(bus.Busy), 32'd1);
    bus.DataIn = 16'hDEAD;
    step();
    bus.Strobe = 1'b0;
    m_ptr = 1;
    repeat (GAP - 1) step();
    chk("t4_count_a", 32'(bus.Count), 32'd1);
    exp_q.push_back({8'd1, 16'hC0DE});
    bus.DataIn = 16'hC0DE;
    bus.Strobe = 1'b1;
    step();
    bus.Strobe = 1'b0;
    bus.Finish = 1'b1;
    step();
    bus.Finish = 1'b0;
    m_ptr = 2;
    repeat (GAP - 1) step();
    chk("t4_not_done", 32'(bus.Done), 32'd0);
    chk("t4_still_hold", 32'(bus.ProcHold), 32'd1);
    chk("t4_count_b", 32'(bus.Count), 32'd2);
    do_finish();
    chk("t4_done", 32'(bus.Done), 32'd1);
    chk("t4_writes", 32'(wr_seen - base), 32'd2);

    // Verify mismatch at address 2.
    if (VERIFY) begin
      corrupt = 1'b1;
      do_start();
      strobe_word(16'h1111, 1'b0);
      strobe_word(16'h2222, 1'b0);
      strobe_word(16'h3333, 1'b1);
      chk("t5_error", 32'(bus.Error), 32'd1);
      chk("t5_addr", 32'(bus.Mem_Addr), 32'd2);
      chk("t5_count", 32'(bus.Count), 32'd2);
      chk("t5_hold", 32'(bus.ProcHold), 32'd1);
      chk("t5_busy", 32'(bus.Busy), 32'd0);
      do_start();
      chk("t5_error_cleared", 32'(bus.Error), 32'd0);
      strobe_word(16'h4444, 1'b0);
      chk("t5_restart_count", 32'(bus.Count), 32'd1);
      do_finish();
      chk("t5_done", 32'(bus.Done), 32'd1);
      corrupt = 1'b0;
    end

    // Reset asserted during WRITE.
    do_start();
    strobe_word(16'h9999, 1'b0);
    exp_q.push_back({8'd1, 16'h8888});
    bus.DataIn = 16'h8888;
    bus.Strobe = 1'b1;
    step();
    bus.Strobe = 1'b0;
    chk("t6_wren_before_reset", 32'(bus.Mem_WrEn), 32'd1);
    rst = 1'b1;
    step();
    check_reset_values();
    rst = 1'b0;
    step();
    check_reset_values();
    do_start();
    strobe_word(16'h6666, 1'b0);
    chk("t6_restart_addr", 32'(bus.Mem_Addr), 32'd0);
    chk("t6_restart_count", 32'(bus.Count), 32'd1);
    do_finish();
    chk("t6_done", 32'(bus.Done), 32'd1);

    repeat (3) step();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Front-panel program loader: the write-side counterpart of the processor's instruction fetch. It takes 16-bit words keyed in on the switches, one per debounced KEY strobe, and writes them into consecutive instruction-memory addresses starting at 0. While loading, it holds the processor in reset. It sits between the ButtonSync/KeyFilter strobe path and the instruction memory write port, alongside Processor, in the lab top level.

## Interface
- ADDR_W, 8, instruction memory address width
- DATA_W, 16, instruction word width
- DEPTH, 256, number of writable words (must be ≤ 2^ADDR_W)

- Clk  input  1  system clock (CLOCK_50 domain)
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle pulse: enter load mode
- Strobe  input  1  one-cycle pulse: write DataIn as next word
- Finish  input  1  one-cycle pulse: end load mode
- DataIn  input  DATA_W  word to write (SW[15:0])
- Mem_RdData  input  DATA_W  memory read data, valid one cycle after Mem_Addr
- Mem_Addr  output  ADDR_W  memory address
- Mem_WrData  output  DATA_W  memory write data
- Mem_WrEn  output  1  write enable, one cycle per word
- ProcHold  output  1  hold the processor in reset; OR'd into the Processor Reset input at the top level
- Count  output  ADDR_W+1  number of words written this session
- Busy  output  1  write or verify in progress; strobes are dropped
- Done  output  1  session ended normally
- Error  output  1  verify mismatch

## Operation
- States: IDLE, WAIT, WRITE, VRD, VCMP, DONE, ERR.
- IDLE: ProcHold=0.
  - Start → WAIT.
  - On entering WAIT, Count is cleared and the write pointer is set to 0.
- WAIT: ProcHold=1.
  - Strobe → WRITE, and DataIn is latched into Mem_WrData.
  - Finish → DONE.
  - If Strobe and Finish arrive in the same cycle, Finish wins and the word is dropped.
  - When Count == DEPTH, Strobe is ignored. The block moves to DONE on the next cycle without waiting for Finish.
- WRITE: Mem_WrEn=1 for exactly one cycle, with Mem_Addr = pointer.
  - With verify compiled in: → VRD.
  - Without verify: the pointer and Count increment, then → WAIT.
- VRD: Mem_Addr is held and Mem_WrEn=0 (read cycle). → VCMP.
- VCMP: Mem_RdData is compared with the latched word.
  - Equal: the pointer and Count increment, then → WAIT.
  - Not equal: → ERR. The pointer and Count do not increment; Mem_Addr keeps the failing address.
- DONE: ProcHold=0 and Done=1.
  - Start → WAIT, which begins a new session from address 0.
- ERR: ProcHold=1 and Error=1.
  - Start → WAIT, which begins a new session.
  - Finish → IDLE, with Error cleared.
- Inputs outside the states listed above are ignored. This includes Start while in WAIT, WRITE, VRD or VCMP.
- Strobe and Finish received while Busy=1 are dropped. They are not queued.
- The pointer never wraps. Count saturates at DEPTH.
- Busy=1 in WRITE, VRD and VCMP.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE
  - Mem_Addr=0, Mem_WrData=0, Mem_WrEn=0
  - ProcHold=0, Count=0
  - Busy=0, Done=0, Error=0
- Reset asserted mid-session takes effect at the next edge. Mem_WrEn drops that cycle, and a pending write or verify is abandoned.
- Start at edge N → ProcHold=1 from N+1.
- Strobe at edge N (in WAIT):
  - Mem_WrEn=1 during N+1..N+2.
  - Without verify: Count increments at N+2, and the next Strobe is accepted from N+2.
  - With verify: the compare happens at N+3, Count increments at N+4 (if equal), and the next Strobe is accepted from N+4.
- Mem_RdData is assumed to come from a synchronous-read RAM with one-cycle latency.

## Configuration
- LOADER_VERIFY_EN
  - Defined: the VRD and VCMP states exist, and the ERR state and Error output are live.
  - Undefined: WRITE returns directly to WAIT, Error is tied to 0, and Mem_RdData is unused.

## Test plan
- Reset, then Start, then Strobes with DataIn=16'h1234, 16'hABCD, 16'h0F0F, then Finish → writes at addresses 0, 1, 2; Count=3; Done=1; ProcHold falls one cycle after Finish.
- Strobe and Finish in the same cycle during WAIT → no Mem_WrEn pulse; DONE is entered; Count is unchanged.
- 257 Strobes with DEPTH=256 → exactly 256 writes (addresses 0..255); Count=256; DONE without Finish; the extra Strobe is dropped.
- Strobe repeated while Busy=1 → exactly one write per accepted strobe; the dropped strobe produces no Mem_WrEn pulse.
- LOADER_VERIFY_EN, with the memory model corrupting address 2 → Error=1; Mem_Addr=2; Count=2; Start restarts from address 0 with Error cleared.
- Reset asserted during WRITE → Mem_WrEn=0 at the next edge; all outputs return to their reset values; a subsequent Start begins at address 0.
